// File: rtl/axi_mem_pkg.sv
// Shared types for the AXI3 scratch memory slave.
// Burst/response encodings, FSM states and response priority.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2,
        RSVD  = 2'd3
    } burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Encodings already rank DECERR > SLVERR > OKAY numerically.
    function automatic logic [1:0] resp_max(
        input logic [1:0] a,
        input logic [1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI3 port bundle between a master driver and the memory slave.
// Master drives requests and data, slave drives readies and responses.
interface axi_mem_slave_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst,
        output awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst,
        input  awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for FIXED/INCR/WRAP bursts.
// Illegal bursts fall back to INCR; oversize beats use full width.
module axi_burst_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4,
    parameter int STRB_W = 4
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              burst_ok,
    output logic              size_ok
);
    localparam int MAX_SIZE = $clog2(STRB_W);

    logic [2:0]        eff_size;
    logic              wrap_len_ok;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] total;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] bound;

    always_comb begin
        size_ok     = (size <= 3'(MAX_SIZE));
        eff_size    = size_ok ? size : 3'(MAX_SIZE);
        inc         = ADDR_W'(1) << eff_size;
        // Wrap lengths must make the wrap window a power of two.
        wrap_len_ok = (len != '0) &&
                      ((len & (len + LEN_W'(1))) == '0);
        total       = (ADDR_W'(len) + ADDR_W'(1)) << eff_size;
        mask        = total - ADDR_W'(1);
        bound       = addr & ~mask;
        burst_ok    = 1'b1;
        next_addr   = addr + inc;
        unique case (burst_e'(burst))
            FIXED: next_addr = addr;
            INCR:  next_addr = addr + inc;
            WRAP: begin
                if (wrap_len_ok) begin
                    next_addr = bound | ((addr + inc) & mask);
                end else begin
                    burst_ok = 1'b0;
                end
            end
            default: burst_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI3 slave terminating into a byte-strobed scratch memory.
// Independent write and read engines, one burst in flight each.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 4,
    parameter int MEM_DEPTH = 1024
) (
    input  logic          aclk,
    input  logic          areset,
    axi_mem_slave_if.slave s
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int WORD_W = ADDR_W - OFF_W;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    w_state_e          w_state, w_next;
    logic [ADDR_W-1:0] w_addr, w_next_addr;
    logic [LEN_W-1:0]  w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q, w_beat_resp;
    logic              w_burst_ok, w_size_ok;
    logic              aw_rdy, w_rdy, b_vld;
    logic              aw_hs, w_hs, w_last, w_hit;
    logic [WORD_W-1:0] w_word;
    logic [IDX_W-1:0]  w_idx;

    r_state_e          r_state, r_next;
    logic [ADDR_W-1:0] r_addr, r_next_addr;
    logic [LEN_W-1:0]  r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [ID_W-1:0]   rid_q;
    logic              r_burst_ok, r_size_ok;
    logic              ar_rdy, r_vld;
    logic              ar_hs, r_hs, r_last, r_hit;
    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic [1:0]        r_beat_resp;

    axi_burst_addr_gen #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .STRB_W(STRB_W)
    ) u_wgen (
        .addr(w_addr), .len(w_len), .size(w_size),
        .burst(w_burst), .next_addr(w_next_addr),
        .burst_ok(w_burst_ok), .size_ok(w_size_ok)
    );

    axi_burst_addr_gen #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .STRB_W(STRB_W)
    ) u_rgen (
        .addr(r_addr), .len(r_len), .size(r_size),
        .burst(r_burst), .next_addr(r_next_addr),
        .burst_ok(r_burst_ok), .size_ok(r_size_ok)
    );

    assign w_word = w_addr[ADDR_W-1:OFF_W];
    assign w_idx  = w_word[IDX_W-1:0];
    assign w_hit  = (w_word < WORD_W'(MEM_DEPTH));
    assign w_last = (w_cnt == w_len);
    assign aw_hs  = s.awvalid && aw_rdy;
    assign w_hs   = s.wvalid && w_rdy;

    always_comb begin
        w_beat_resp = OKAY;
        if (!w_burst_ok || !w_size_ok) w_beat_resp = SLVERR;
        if (s.wid != bid_q)            w_beat_resp = SLVERR;
        if (s.wlast != w_last)         w_beat_resp = SLVERR;
        if (!w_hit)                    w_beat_resp = DECERR;
    end

    always_ff @(posedge aclk) begin
        if (areset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Readies are masked during reset so nothing handshakes then.
    always_comb begin
        w_next = w_state;
        aw_rdy = 1'b0;
        w_rdy  = 1'b0;
        b_vld  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                aw_rdy = !areset;
                if (s.awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                w_rdy = !areset;
                if (s.wvalid && w_last) w_next = W_RESP;
            end
            W_RESP: begin
                b_vld = !areset;
                if (s.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            bid_q   <= '0;
            bresp_q <= OKAY;
        end else begin
            if (aw_hs) begin
                w_addr  <= s.awaddr;
                w_len   <= s.awlen;
                w_cnt   <= '0;
                w_size  <= s.awsize;
                w_burst <= s.awburst;
                bid_q   <= s.awid;
                bresp_q <= OKAY;
            end
            if (w_hs) begin
                w_addr  <= w_next_addr;
                w_cnt   <= w_cnt + LEN_W'(1);
                bresp_q <= resp_max(bresp_q, w_beat_resp);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && w_hit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s.wstrb[b]) begin
                    mem[w_idx][8*b +: 8] <= s.wdata[8*b +: 8];
                end
            end
        end
    end

    assign s.awready = aw_rdy;
    assign s.wready  = w_rdy;
    assign s.bvalid  = b_vld;
    assign s.bid     = bid_q;
    assign s.bresp   = bresp_q;

    assign r_word = r_addr[ADDR_W-1:OFF_W];
    assign r_idx  = r_word[IDX_W-1:0];
    assign r_hit  = (r_word < WORD_W'(MEM_DEPTH));
    assign r_last = (r_cnt == r_len);
    assign ar_hs  = s.arvalid && ar_rdy;
    assign r_hs   = r_vld && s.rready;

    always_comb begin
        r_beat_resp = OKAY;
        if (!r_burst_ok || !r_size_ok) r_beat_resp = SLVERR;
        if (!r_hit)                    r_beat_resp = DECERR;
    end

    always_ff @(posedge aclk) begin
        if (areset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        ar_rdy = 1'b0;
        r_vld  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                ar_rdy = !areset;
                if (s.arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                r_vld = !areset;
                if (s.rready && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            rid_q   <= '0;
        end else begin
            if (ar_hs) begin
                r_addr  <= s.araddr;
                r_len   <= s.arlen;
                r_cnt   <= '0;
                r_size  <= s.arsize;
                r_burst <= s.arburst;
                rid_q   <= s.arid;
            end
            if (r_hs) begin
                r_addr <= r_next_addr;
                r_cnt  <= r_cnt + LEN_W'(1);
            end
        end
    end

    // Asynchronous read port: same-cycle writes show up next cycle.
    assign s.arready = ar_rdy;
    assign s.rvalid  = r_vld;
    assign s.rid     = rid_q;
    assign s.rdata   = (r_vld && r_hit) ? mem[r_idx] : '0;
    assign s.rresp   = r_vld ? r_beat_resp : OKAY;
    assign s.rlast   = r_vld && r_last;

    logic unused_ok;
    assign unused_ok = ^{s.awlock, s.awcache, s.awprot,
                         s.arlock, s.arcache, s.arprot};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomised AXI3 traffic against a byte-array memory model.
// Directed corner cases first, then random bursts.
module tb_axi_mem_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axi_mem_slave_if bus ();

    axi_mem_slave dut (
        .aclk(aclk),
        .areset(areset),
        .s(bus)
    );

    int total = 0;
    int bad = 0;

    logic [7:0]  mm [0:4095];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rbeat [16];
    logic [1:0]  rr [16];
    logic        rl [16];
    logic [1:0]  got_bresp;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] worst(input logic [1:0] a,
                                         input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] a,
                                           input int len, input int size,
                                           input int burst);
        longint unsigned inc, tot, bnd, aa;
        inc = longint'(1) << ((size > 2) ? 2 : size);
        aa = a;
        if (burst == 0) return a;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            tot = longint'(len + 1) * inc;
            bnd = (aa / tot) * tot;
            return 32'(bnd + ((aa + inc - bnd) % tot));
        end
        return 32'(aa + inc);
    endfunction

    function automatic logic [1:0] m_flag(input int len, input int size,
                                          input int burst);
        if (burst == 3) return SLVERR;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
            return SLVERR;
        if (size > 2) return SLVERR;
        return OKAY;
    endfunction

    function automatic logic [1:0] m_dec(input logic [31:0] a);
        return ((a >> 2) >= 1024) ? DECERR : OKAY;
    endfunction

    task automatic m_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st);
        int w;
        w = int'(a >> 2);
        if ((a >> 2) < 1024) begin
            for (int j = 0; j < 4; j++)
                if (st[j]) mm[w*4+j] = d[8*j +: 8];
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        int w;
        if ((a >> 2) >= 1024) return 32'h0;
        w = int'(a >> 2);
        return {mm[w*4+3], mm[w*4+2], mm[w*4+1], mm[w*4]};
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr,
                             input int len, input int size, input int burst,
                             input int wl_at, input bit bad_wid,
                             input int bdly);
        logic [31:0] a;
        logic [1:0]  er;
        int n;
        bit to;
        to = 0;
        er = m_flag(len, size, burst);
        if (bad_wid || wl_at != len) er = worst(er, SLVERR);
        @(negedge aclk);
        bus.awvalid = 1'b1;
        bus.awid    = id;
        bus.awaddr  = addr;
        bus.awlen   = 4'(len);
        bus.awsize  = 3'(size);
        bus.awburst = 2'(burst);
        bus.awlock  = 2'($urandom);
        bus.awcache = 4'($urandom);
        bus.awprot  = 3'($urandom);
        n = 0;
        while (!bus.awready && n < 100) begin @(negedge aclk); n++; end
        if (n >= 100) to = 1;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        check("wready_lat", 64'(bus.wready), 64'(1));
        a = addr;
        for (int b = 0; b <= len; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.wvalid = 1'b0;
                @(negedge aclk);
            end
            bus.wvalid = 1'b1;
            bus.wdata  = wd[b];
            bus.wstrb  = ws[b];
            bus.wlast  = (b == wl_at);
            bus.wid    = bad_wid ? ~id : id;
            n = 0;
            while (!bus.wready && n < 100) begin @(negedge aclk); n++; end
            if (n >= 100) to = 1;
            @(negedge aclk);
            m_wr(a, wd[b], ws[b]);
            er = worst(er, m_dec(a));
            a = m_next(a, len, size, burst);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        check("w_timeout", 64'(to), 64'(0));
        check("bvalid_lat", 64'(bus.bvalid), 64'(1));
        for (int i = 0; i < bdly; i++) begin
            check("bhold_valid", 64'(bus.bvalid), 64'(1));
            check("bhold_id", 64'(bus.bid), 64'(id));
            @(negedge aclk);
        end
        check("bid", 64'(bus.bid), 64'(id));
        check("bresp", 64'(bus.bresp), 64'(er));
        got_bresp = bus.bresp;
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        check("b_done", 64'(bus.bvalid), 64'(0));
        check("aw_back", 64'(bus.awready), 64'(1));
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr,
                            input int len, input int size, input int burst);
        logic [31:0] a;
        logic [1:0]  fl;
        int n, beat;
        bit go;
        fl = m_flag(len, size, burst);
        @(negedge aclk);
        bus.arvalid = 1'b1;
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = 4'(len);
        bus.arsize  = 3'(size);
        bus.arburst = 2'(burst);
        bus.arlock  = 2'($urandom);
        bus.arcache = 4'($urandom);
        bus.arprot  = 3'($urandom);
        n = 0;
        while (!bus.arready && n < 100) begin @(negedge aclk); n++; end
        check("ar_timeout", 64'(n >= 100), 64'(0));
        @(negedge aclk);
        bus.arvalid = 1'b0;
        check("rvalid_lat", 64'(bus.rvalid), 64'(1));
        a = addr;
        beat = 0;
        n = 0;
        while (beat <= len && n < 500) begin
            go = 0;
            if (bus.rvalid) begin
                check("rdata", 64'(bus.rdata), 64'(m_rd(a)));
                check("rresp", 64'(bus.rresp), 64'(worst(fl, m_dec(a))));
                check("rlast", 64'(bus.rlast), 64'(beat == len));
                check("rid", 64'(bus.rid), 64'(id));
                rbeat[beat] = bus.rdata;
                rr[beat] = bus.rresp;
                rl[beat] = bus.rlast;
                go = ($urandom_range(0, 3) != 0);
            end
            bus.rready = go;
            @(negedge aclk);
            n++;
            if (go) begin
                a = m_next(a, len, size, burst);
                beat++;
            end
        end
        bus.rready = 1'b0;
        check("r_timeout", 64'(n >= 500), 64'(0));
        check("r_done", 64'(bus.rvalid), 64'(0));
        check("ar_back", 64'(bus.arready), 64'(1));
    endtask

    initial begin
        int hits;
        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0;
        bus.awsize = 0; bus.awburst = 0; bus.awlock = 0;
        bus.awcache = 0; bus.awprot = 0;
        bus.wvalid = 0; bus.wid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0;
        bus.arsize = 0; bus.arburst = 0; bus.arlock = 0;
        bus.arcache = 0; bus.arprot = 0; bus.rready = 0;

        areset = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_awready", 64'(bus.awready), 64'(0));
        check("rst_wready", 64'(bus.wready), 64'(0));
        check("rst_bvalid", 64'(bus.bvalid), 64'(0));
        check("rst_arready", 64'(bus.arready), 64'(0));
        check("rst_rvalid", 64'(bus.rvalid), 64'(0));
        check("rst_bid", 64'(bus.bid), 64'(0));
        check("rst_bresp", 64'(bus.bresp), 64'(0));
        check("rst_rid", 64'(bus.rid), 64'(0));
        check("rst_rdata", 64'(bus.rdata), 64'(0));
        check("rst_rresp", 64'(bus.rresp), 64'(0));
        check("rst_rlast", 64'(bus.rlast), 64'(0));
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_aw", 64'(bus.awready), 64'(1));
        check("post_rst_ar", 64'(bus.arready), 64'(1));

        // Fill the whole memory so every later read is defined.
        for (int i = 0; i < 64; i++) begin
            for (int b = 0; b < 16; b++) begin
                wd[b] = $urandom;
                ws[b] = 4'hF;
            end
            axi_write(4'(i), 32'(i * 64), 15, 2, 1, 15, 0, 0);
        end

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(4'h1, 32'h10, 0, 2, 1, 0, 0, 0);
        check("t1_bresp", 64'(got_bresp), 64'(OKAY));
        axi_read(4'h2, 32'h10, 0, 2, 1);
        check("t1_rdata", 64'(rbeat[0]), 64'h0000_0000_DEAD_BEEF);
        check("t1_rresp", 64'(rr[0]), 64'(OKAY));
        check("t1_rlast", 64'(rl[0]), 64'(1));

        for (int b = 0; b < 4; b++) begin
            wd[b] = 32'(b + 1);
            ws[b] = 4'hF;
        end
        axi_write(4'h6, 32'h100, 3, 2, 1, 3, 0, 5);
        check("t2_bresp", 64'(got_bresp), 64'(OKAY));
        axi_read(4'h7, 32'h100, 3, 2, 1);
        for (int b = 0; b < 4; b++) begin
            check("t2_rdata", 64'(rbeat[b]), 64'(b + 1));
            check("t2_rlast", 64'(rl[b]), 64'(b == 3));
        end

        axi_read(4'h8, 32'h108, 3, 2, 2);
        check("wrap_b0", 64'(rbeat[0]), 64'(3));
        check("wrap_b1", 64'(rbeat[1]), 64'(4));
        check("wrap_b2", 64'(rbeat[2]), 64'(1));
        check("wrap_b3", 64'(rbeat[3]), 64'(2));

        wd[0] = 32'h0; ws[0] = 4'hF;
        axi_write(4'h3, 32'h0, 0, 2, 1, 0, 0, 0);
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'h3;
        axi_write(4'h3, 32'h0, 0, 2, 1, 0, 0, 1);
        axi_read(4'h3, 32'h0, 0, 2, 1);
        check("strb_rdata", 64'(rbeat[0]), 64'h0000_FFFF);

        wd[0] = 32'h12345678; wd[1] = 32'h9ABCDEF0;
        ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(4'h4, 32'h1000, 1, 2, 1, 1, 0, 0);
        check("dec_bresp", 64'(got_bresp), 64'(DECERR));
        axi_read(4'h4, 32'h1000, 1, 2, 1);
        for (int b = 0; b < 2; b++) begin
            check("dec_rdata", 64'(rbeat[b]), 64'(0));
            check("dec_rresp", 64'(rr[b]), 64'(DECERR));
        end

        for (int b = 0; b < 4; b++) begin
            wd[b] = $urandom;
            ws[b] = 4'hF;
        end
        axi_write(4'h5, 32'h140, 3, 2, 1, 1, 0, 0);
        check("wlast_bresp", 64'(got_bresp), 64'(SLVERR));
        axi_read(4'h5, 32'h140, 3, 2, 3);
        check("rsvd_rresp", 64'(rr[3]), 64'(SLVERR));
        check("rsvd_rlast", 64'(rl[3]), 64'(1));

        // Reset in the middle of a write burst and a read burst.
        @(negedge aclk);
        check("mid_aw_rdy", 64'(bus.awready), 64'(1));
        bus.awvalid = 1; bus.awid = 4'h3; bus.awaddr = 32'h200;
        bus.awlen = 4'd3; bus.awsize = 3'd2; bus.awburst = 2'd1;
        @(negedge aclk);
        bus.awvalid = 0;
        bus.wvalid = 1; bus.wid = 4'h3; bus.wdata = 32'hA5A50001;
        bus.wstrb = 4'hF; bus.wlast = 0;
        @(negedge aclk);
        bus.wvalid = 0;
        m_wr(32'h200, 32'hA5A50001, 4'hF);
        check("mid_ar_rdy", 64'(bus.arready), 64'(1));
        bus.arvalid = 1; bus.arid = 4'h9; bus.araddr = 32'h300;
        bus.arlen = 4'd7; bus.arsize = 3'd2; bus.arburst = 2'd1;
        @(negedge aclk);
        bus.arvalid = 0;
        bus.rready = 1;
        @(negedge aclk);
        bus.rready = 0;
        check("mid_rvalid", 64'(bus.rvalid), 64'(1));
        areset = 1'b1;
        @(negedge aclk);
        check("mid_rst_aw", 64'(bus.awready), 64'(0));
        check("mid_rst_ar", 64'(bus.arready), 64'(0));
        check("mid_rst_rid", 64'(bus.rid), 64'(0));
        check("mid_rst_rdata", 64'(bus.rdata), 64'(0));
        areset = 1'b0;
        @(negedge aclk);
        check("mid_post_aw", 64'(bus.awready), 64'(1));
        check("mid_post_ar", 64'(bus.arready), 64'(1));
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.bvalid || bus.rvalid) hits++;
            @(negedge aclk);
        end
        check("mid_no_resp", 64'(hits), 64'(0));
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        axi_write(4'hA, 32'h204, 0, 2, 1, 0, 0, 0);
        check("mid_new_bresp", 64'(got_bresp), 64'(OKAY));
        axi_read(4'hB, 32'h200, 1, 2, 1);
        check("mid_new_rresp", 64'(rr[1]), 64'(OKAY));
        check("mid_new_rdata", 64'(rbeat[1]), 64'h0000_0000_CAFE_F00D);

        for (int t = 0; t < 40; t++) begin
            int len, size, burst, wl_at;
            logic [31:0] addr;
            len   = $urandom_range(0, 15);
            size  = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 7)
                                                : $urandom_range(0, 2);
            burst = $urandom_range(0, 3);
            addr  = ($urandom_range(0, 7) == 0)
                    ? 32'(32'hFF0 + $urandom_range(0, 63))
                    : 32'($urandom_range(0, 4095));
            wl_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16)
                                                : len;
            for (int b = 0; b < 16; b++) begin
                wd[b] = $urandom;
                ws[b] = 4'($urandom_range(0, 15));
            end
            axi_write(4'($urandom), addr, len, size, burst, wl_at,
                      ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
            len   = $urandom_range(0, 15);
            size  = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 7)
                                                : $urandom_range(0, 2);
            burst = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0)
                addr = 32'($urandom_range(0, 4200));
            axi_read(4'($urandom), addr, len, size, burst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
